fir_channel_scheduler: RTL and testbench

//  Time-shares one FIR filter datapath (constant-coefficient multiply block with input and output

---
 rtl/fir_channel_scheduler.sv | 117 +++++++++++
 tb/tb_fir_channel_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
//   Shares one constant-coefficient FIR datapath among NUM_CH receiver channels.
//   A work-conserving round-robin arbiter grants at most one sample per cycle.
//   The granted sample is registered onto fir_in. A tag pipe carries
//   {valid, channel} alongside the filter latency so each result is labelled.
//
// Ports
//   CLK        in   system clock, rising edge
//   reset_n    in   async active-low reset
//   enable     in   1 = accept samples; 0 = finish in-flight work, then idle
//   req_valid  in   per-channel sample valid
//   req_data   in   per-channel samples, ch i at [i*DATA_W +: DATA_W]
//   req_ready  out  one-hot grant (RUN only)
//   fir_in     out  registered sample to the filter input
//   fir_out    in   filter output
//   res_valid  out  one-cycle result strobe
//   res_ch     out  channel tag of the current result
//   res_data   out  fir_out while res_valid, else 0
//   busy       out  not idle, or samples still in flight
//
// FSM states
//   state | meaning
//   IDLE  | no arbitration; waits for enable
//   RUN   | arbitrating, one grant per cycle at most
//   DRAIN | no grants; waits for the tag pipe to empty (enable ignored)

module fir_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DATA_W  = 32,
  parameter int FIR_LAT = 2
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [DATA_W-1:0]        fir_in,
  input  logic [DATA_W-1:0]        fir_out,
  output logic                     res_valid,
  output logic [CH_W-1:0]          res_ch,
  output logic [DATA_W-1:0]        res_data,
  output logic                     busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [CH_W-1:0]  rrPtr;
  logic [CH_W-1:0]  grantCh;
  logic             grantFound;
  logic             handshake;
  logic             pipeEmpty;
  logic [FIR_LAT:0] tagValid;
  logic [CH_W-1:0]  tagCh [0:FIR_LAT];

  // Round-robin search: start one past the last granted channel, ascend with wrap.
  always_comb begin
    logic [CH_W-1:0] idx;
    grantCh    = '0;
    grantFound = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(rrPtr) + k) % NUM_CH);
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantCh    = idx;
      end
    end
  end

  assign req_ready = (state == RUN && grantFound) ? (NUM_CH'(1) << grantCh) : '0;
  assign handshake = |(req_valid & req_ready);
  assign pipeEmpty = ~|tagValid;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (enable)    stateNext = RUN;
      RUN:     if (!enable)   stateNext = DRAIN;
      DRAIN:   if (pipeEmpty) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rrPtr    <= CH_W'(NUM_CH - 1);
      fir_in   <= '0;
      tagValid <= '0;
      for (int i = 0; i <= FIR_LAT; i++) tagCh[i] <= '0;
    end else begin
      state <= stateNext;
      if (handshake) begin
        rrPtr  <= grantCh;
        fir_in <= req_data[int'(grantCh)*DATA_W +: DATA_W];
      end else begin
        fir_in <= '0;
      end
      // Stage 0 lines up with fir_in; the last stage lines up with fir_out.
      tagValid <= {tagValid[FIR_LAT-1:0], handshake};
      tagCh[0] <= handshake ? grantCh : '0;
      for (int i = 1; i <= FIR_LAT; i++) tagCh[i] <= tagCh[i-1];
    end
  end

  assign res_valid = tagValid[FIR_LAT];
  assign res_ch    = tagCh[FIR_LAT];
  assign res_data  = tagValid[FIR_LAT] ? fir_out : '0;
  assign busy      = (state != IDLE) || !pipeEmpty;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// tb_fir_channel_scheduler
//   Directed bench for fir_channel_scheduler with a two-register constant-
//   coefficient filter model (y = (x * -362) >>> 12) attached to fir_in/fir_out.

module tb_fir_channel_scheduler;

  logic         CLK;
  logic         reset_n;
  logic         enable;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  fir_in;
  logic [31:0]  fir_out;
  logic         res_valid;
  logic [1:0]   res_ch;
  logic [31:0]  res_data;
  logic         busy;

  int checkCnt = 0;
  int errCnt   = 0;

  fir_channel_scheduler #(
    .NUM_CH(4), .CH_W(2), .DATA_W(32), .FIR_LAT(2)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fir_in(fir_in), .fir_out(fir_out),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Filter model: input register, multiply, output register.
  logic [31:0]        filtIn;
  logic signed [63:0] prod;
  assign prod = $signed(filtIn) * -64'sd362;
  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      filtIn  <= '0;
      fir_out <= '0;
    end else begin
      filtIn  <= fir_in;
      fir_out <= prod[43:12];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
  task automatic driveSlot();
    @(posedge CLK);
    #1;
  endtask

  task automatic sampleSlot();
    @(negedge CLK);
  endtask

  // Filter results for samples (i+1)*0x1000: -362, -724, -1086, -1448
  logic [31:0] expRes [0:3];
  logic [1:0]  t3Grant [0:8];
  logic [3:0]  t4Valid [0:7];
  logic [1:0]  t4Grant [0:7];

  initial begin
    expRes[0] = 32'hFFFF_FE96; expRes[1] = 32'hFFFF_FD2C;
    expRes[2] = 32'hFFFF_FBC2; expRes[3] = 32'hFFFF_FA58;
    t3Grant[0] = 2'd3; t3Grant[1] = 2'd0; t3Grant[2] = 2'd1; t3Grant[3] = 2'd2; t3Grant[4] = 2'd3;
    t3Grant[5] = 2'd0; t3Grant[6] = 2'd1; t3Grant[7] = 2'd2; t3Grant[8] = 2'd3;
    t4Valid[0] = 4'b0010; t4Valid[1] = 4'b1010; t4Valid[2] = 4'b1010; t4Valid[3] = 4'b1010;
    t4Valid[4] = 4'b1010; t4Valid[5] = 4'b1011; t4Valid[6] = 4'b1011; t4Valid[7] = 4'b1011;
    t4Grant[0] = 2'd1; t4Grant[1] = 2'd3; t4Grant[2] = 2'd1; t4Grant[3] = 2'd3;
    t4Grant[4] = 2'd1; t4Grant[5] = 2'd3; t4Grant[6] = 2'd0; t4Grant[7] = 2'd1;

    reset_n   = 1'b0;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(posedge CLK);
    sampleSlot();
    checkVal("rst_ready",  {28'd0, req_ready}, 32'd0);
    checkVal("rst_fir_in", fir_in, 32'd0);
    checkVal("rst_valid",  {31'd0, res_valid}, 32'd0);
    checkVal("rst_ch",     {30'd0, res_ch}, 32'd0);
    checkVal("rst_data",   res_data, 32'd0);
    checkVal("rst_busy",   {31'd0, busy}, 32'd0);

    // Single ch2 sample through the filter
    driveSlot();
    reset_n = 1'b1;
    driveSlot();
    enable = 1'b1;
    sampleSlot();
    checkVal("idle_ready", {28'd0, req_ready}, 32'd0);
    driveSlot();
    req_valid = 4'b0100;
    req_data[2*32 +: 32] = 32'h0000_1000;
    sampleSlot();
    checkVal("t2_grant", {28'd0, req_ready}, 32'h4);
    checkVal("t2_busy",  {31'd0, busy}, 32'd1);
    driveSlot();
    req_valid = '0;
    sampleSlot();
    checkVal("t2_fir_in", fir_in, 32'h0000_1000);
    checkVal("t2_v1",     {31'd0, res_valid}, 32'd0);
    driveSlot();
    sampleSlot();
    checkVal("t2_v2", {31'd0, res_valid}, 32'd0);
    driveSlot();
    sampleSlot();
    checkVal("t2_valid", {31'd0, res_valid}, 32'd1);
    checkVal("t2_ch",    {30'd0, res_ch}, 32'd2);
    checkVal("t2_data",  res_data, 32'hFFFF_FE96);
    driveSlot();
    sampleSlot();
    checkVal("t2_after_valid", {31'd0, res_valid}, 32'd0);
    checkVal("t2_after_data",  res_data, 32'd0);

    // Continuous requests: ch3 alone once, then all four
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'((i + 1) * 32'h1000);
    for (int k = 0; k < 12; k++) begin
      driveSlot();
      req_valid = (k == 0) ? 4'b1000 : (k < 9) ? 4'b1111 : 4'b0000;
      sampleSlot();
      if (k < 9) checkVal($sformatf("t3_grant%0d", k), {28'd0, req_ready}, 32'(4'b0001 << t3Grant[k]));
      else       checkVal($sformatf("t3_grant%0d", k), {28'd0, req_ready}, 32'd0);
      if (k >= 3) begin
        checkVal($sformatf("t3_valid%0d", k), {31'd0, res_valid}, 32'd1);
        checkVal($sformatf("t3_ch%0d", k),    {30'd0, res_ch}, {30'd0, t3Grant[k-3]});
        checkVal($sformatf("t3_data%0d", k),  res_data, expRes[t3Grant[k-3]]);
      end
    end

    // ch1/ch3 alternate, then ch0 joins
    for (int j = 0; j < 8; j++) begin
      driveSlot();
      req_valid = t4Valid[j];
      sampleSlot();
      checkVal($sformatf("t4_grant%0d", j), {28'd0, req_ready}, 32'(4'b0001 << t4Grant[j]));
    end
    driveSlot();
    req_valid = '0;
    repeat (4) driveSlot();

    // Drain with enable dropped on a handshake cycle, enable re-raised during DRAIN
    req_valid = 4'b0100;
    sampleSlot();
    checkVal("t5_grant_u0", {28'd0, req_ready}, 32'h4);
    driveSlot();
    req_valid = 4'b0001;
    enable    = 1'b0;
    sampleSlot();
    checkVal("t5_grant_u1", {28'd0, req_ready}, 32'h1);
    driveSlot();
    req_valid = 4'b1111;
    sampleSlot();
    checkVal("t5_drain_ready2", {28'd0, req_ready}, 32'd0);
    checkVal("t5_busy2",        {31'd0, busy}, 32'd1);
    driveSlot();
    enable = 1'b1;
    sampleSlot();
    checkVal("t5_drain_ready3", {28'd0, req_ready}, 32'd0);
    checkVal("t5_res3_valid",   {31'd0, res_valid}, 32'd1);
    checkVal("t5_res3_ch",      {30'd0, res_ch}, 32'd2);
    checkVal("t5_res3_data",    res_data, expRes[2]);
    driveSlot();
    sampleSlot();
    checkVal("t5_drain_ready4", {28'd0, req_ready}, 32'd0);
    checkVal("t5_res4_valid",   {31'd0, res_valid}, 32'd1);
    checkVal("t5_res4_ch",      {30'd0, res_ch}, 32'd0);
    checkVal("t5_res4_data",    res_data, expRes[0]);
    driveSlot();
    sampleSlot();
    checkVal("t5_drain_ready5", {28'd0, req_ready}, 32'd0);
    checkVal("t5_res5_valid",   {31'd0, res_valid}, 32'd0);
    checkVal("t5_busy5",        {31'd0, busy}, 32'd1);
    driveSlot();
    sampleSlot();
    checkVal("t6_idle_ready6", {28'd0, req_ready}, 32'd0);
    checkVal("t5_busy6",       {31'd0, busy}, 32'd0);
    driveSlot();
    sampleSlot();
    checkVal("t6_run_grant7", {28'd0, req_ready}, 32'h2);
    checkVal("t6_busy7",      {31'd0, busy}, 32'd1);

    // Reset mid-run with samples in flight
    driveSlot();
    reset_n = 1'b0;
    #1;
    checkVal("t1_ready",  {28'd0, req_ready}, 32'd0);
    checkVal("t1_fir_in", fir_in, 32'd0);
    checkVal("t1_valid",  {31'd0, res_valid}, 32'd0);
    checkVal("t1_ch",     {30'd0, res_ch}, 32'd0);
    checkVal("t1_data",   res_data, 32'd0);
    checkVal("t1_busy",   {31'd0, busy}, 32'd0);
    req_valid = '0;
    enable    = 1'b0;
    driveSlot();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      driveSlot();
      sampleSlot();
      checkVal($sformatf("t1_post_valid%0d", k), {31'd0, res_valid}, 32'd0);
      checkVal($sformatf("t1_post_busy%0d", k),  {31'd0, busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
